// File: rtl/gaussian_pkg.sv
// rtl/gaussian_pkg.sv - shared types for the gaussian kernel and its write-back buffer
package gaussian_pkg;

   typedef logic [511:0] t_hc_line;
   typedef logic [31:0]  t_hc_count;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_RUN,
      WB_DONE
   } t_wb_state;

endpackage

// File: rtl/gaussian_wb_fifo.sv
// rtl/gaussian_wb_fifo.sv - line FIFO with registered output stage, count includes the output register
module gaussian_wb_fifo #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 512
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [DATA_WIDTH-1:0]        i_push_data,
   input  logic                         i_pop,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [$clog2(DEPTH):0]       o_count
);
   import gaussian_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;

   logic          w_pop;
   logic          w_full;
   logic          w_push_taken;
   logic [CW-1:0] w_mem_count;
   logic          w_mem_empty;
   logic          w_load;
   logic          w_bypass;
   logic          w_mem_wr;
   logic          w_mem_rd;

   // The output register holds the head line; the array holds at most DEPTH-1 lines behind it,
   // so a read slot and a write slot never coincide in the same cycle.
   assign w_pop        = r_out_valid & i_pop;
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_push_taken = i_push & (~w_full | w_pop);
   assign w_mem_count  = r_count - CW'(r_out_valid);
   assign w_mem_empty  = (w_mem_count == '0);
   assign w_load       = ~r_out_valid | w_pop;
   assign w_bypass     = w_push_taken & w_load & w_mem_empty;
   assign w_mem_wr     = w_push_taken & ~w_bypass;
   assign w_mem_rd     = w_load & ~w_mem_empty;

   assign o_data  = r_out_data;
   assign o_empty = ~r_out_valid;
   assign o_full  = w_full;
   assign o_count = r_count;

   // Line storage; contents need no reset because occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (w_mem_wr) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Pointers, occupancy and the output register (refilled from the array, or bypassed when the array is empty).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_mem_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_mem_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push_taken) - CW'(w_pop);
         if (w_load) begin
            if (w_mem_rd) begin
               r_out_data  <= r_mem[r_rd_ptr];
               r_out_valid <= 1'b1;
            end else if (w_bypass) begin
               r_out_data  <= i_push_data;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/gaussian_wb_buffer.sv
// rtl/gaussian_wb_buffer.sv - write-back buffer: line FIFO, read credits, job line counter, sticky errors
module gaussian_wb_buffer #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 512,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  rd_issue,
   output logic                  credit_ok,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  expected_lines,
   output logic [CNT_WIDTH-1:0]  lines_done,
   output logic                  done,
   output logic                  err_overflow,
   output logic                  err_unexpected
);
   import gaussian_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]        w_count;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_pop;
   logic                 w_start_ok;
   logic [CNT_WIDTH:0]   w_credit_sum;
   t_wb_state            w_state_next;

   t_wb_state            r_state;
   logic [CNT_WIDTH-1:0] r_inflight;
   logic [CNT_WIDTH-1:0] r_expected;
   logic [CNT_WIDTH-1:0] r_lines_done;
   logic                 r_err_overflow;
   logic                 r_err_unexpected;

   gaussian_wb_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (valid_in),
      .i_push_data (data_in),
      .i_pop       (ready_in),
      .o_data      (data_out),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full),
      .o_count     (w_count)
   );

   assign valid_out      = ~w_fifo_empty;
   assign w_pop          = valid_out & ready_in;
   assign w_start_ok     = start & (r_state != WB_RUN);
   // Reserved space counts both lines already held and lines still owed by outstanding reads.
   assign w_credit_sum   = {1'b0, r_inflight} + (CNT_WIDTH+1)'(w_count);
   assign credit_ok      = (w_credit_sum < (CNT_WIDTH+1)'(DEPTH));
   assign lines_done     = r_lines_done;
   assign done           = (r_state == WB_DONE);
   assign err_overflow   = r_err_overflow;
   assign err_unexpected = r_err_unexpected;

   // Outstanding read tracking; a stray line never drives the count below zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inflight <= '0;
      end else begin
         case ({rd_issue, valid_in})
            2'b10:   r_inflight <= r_inflight + CNT_WIDTH'(1);
            2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - CNT_WIDTH'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_overflow   <= 1'b0;
         r_err_unexpected <= 1'b0;
      end else begin
         if (valid_in && w_fifo_full && !w_pop) r_err_overflow <= 1'b1;
         if (valid_in && (r_inflight == '0))    r_err_unexpected <= 1'b1;
      end
   end

   // Job state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= WB_IDLE;
      else        r_state <= w_state_next;
   end

   // Job next-state: finish once the registered line count matches the programmed total.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WB_IDLE: if (start) w_state_next = WB_RUN;
         WB_RUN:  if (r_lines_done == r_expected) w_state_next = WB_DONE;
         WB_DONE: if (start) w_state_next = WB_RUN;
         default: w_state_next = WB_IDLE;
      endcase
   end

   // Job counters: loaded on an accepted start, advanced only by pops while running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_expected   <= '0;
         r_lines_done <= '0;
      end else if (w_start_ok) begin
         r_expected   <= expected_lines;
         r_lines_done <= '0;
      end else if ((r_state == WB_RUN) && w_pop && (r_lines_done != r_expected)) begin
         r_lines_done <= r_lines_done + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_gaussian_wb_buffer.sv
// tb/tb_gaussian_wb_buffer.sv - scoreboard bench for gaussian_wb_buffer
module tb_gaussian_wb_buffer;

   localparam int DEPTH = 64;
   localparam int DW    = 512;
   localparam int CNW   = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [DW-1:0]  data_in = '0;
   logic           valid_in = 1'b0;
   logic           rd_issue = 1'b0;
   logic           credit_ok;
   logic [DW-1:0]  data_out;
   logic           valid_out;
   logic           ready_in = 1'b0;
   logic           start = 1'b0;
   logic [CNW-1:0] expected_lines = '0;
   logic [CNW-1:0] lines_done;
   logic           done;
   logic           err_overflow;
   logic           err_unexpected;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] sb_q[$];

   gaussian_wb_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_WIDTH(CNW)) dut (
      .clk            (clk),
      .reset          (reset),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .rd_issue       (rd_issue),
      .credit_ok      (credit_ok),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .start          (start),
      .expected_lines (expected_lines),
      .lines_done     (lines_done),
      .done           (done),
      .err_overflow   (err_overflow),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int tag);
      logic [31:0] w;
      w = 32'h5A5A_0000 ^ 32'(tag);
      return {16{w}};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_lines(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         rd_issue = 1'b1;
         tick();
      end
      rd_issue = 1'b0;
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         data_in  = mk(base + i);
         sb_q.push_back(mk(base + i));
         tick();
      end
      valid_in = 1'b0;
   endtask

   task automatic pulse_start(input logic [CNW-1:0] exp_lines);
      start          = 1'b1;
      expected_lines = exp_lines;
      tick();
      start = 1'b0;
   endtask

   // Monitor: every presented line must match the head of the scoreboard; a stalled line is re-checked each cycle.
   always @(negedge clk) begin
      if (reset && valid_out) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_line: got %0h expected no line", data_out);
         end else begin
            check("sb_data", data_out, sb_q[0]);
            if (ready_in) void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] a5;
      bit            seen;
      a5 = {64{8'hA5}};

      // reset values
      tick();
      tick();
      check("rst_valid_out", DW'(valid_out), DW'(0));
      check("rst_data_out", data_out, '0);
      check("rst_credit_ok", DW'(credit_ok), DW'(1));
      check("rst_lines_done", DW'(lines_done), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_err_ovf", DW'(err_overflow), DW'(0));
      check("rst_err_unexp", DW'(err_unexpected), DW'(0));
      reset = 1'b1;
      tick();

      // single line: read at cycle 0, data at cycle 5, visible at cycle 6
      ready_in = 1'b1;
      rd_issue = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("single_credit", DW'(credit_ok), DW'(1));
         if (c == 5) begin
            valid_in = 1'b1;
            data_in  = a5;
            sb_q.push_back(a5);
         end
         tick();
         rd_issue = 1'b0;
         valid_in = 1'b0;
      end
      check("single_valid_n1", DW'(valid_out), DW'(1));
      check("single_data_n1", data_out, a5);
      check("single_credit_end", DW'(credit_ok), DW'(1));
      tick();
      check("single_valid_after", DW'(valid_out), DW'(0));

      // credit exhaustion, then backpressure fill and full-rate drain
      ready_in = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("credit_63_inflight", DW'(credit_ok), DW'(1));
         rd_issue = 1'b1;
         tick();
      end
      rd_issue = 1'b0;
      check("credit_64_inflight", DW'(credit_ok), DW'(0));
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1;
         data_in  = mk(1000 + i);
         sb_q.push_back(mk(1000 + i));
         tick();
      end
      valid_in = 1'b0;
      check("credit_full", DW'(credit_ok), DW'(0));
      check("full_no_overflow", DW'(err_overflow), DW'(0));
      for (int i = 0; i < 4; i++) tick();
      check("stall_data_held", data_out, mk(1000));
      ready_in = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_valid", DW'(valid_out), DW'(1));
         if (i == 1) check("credit_after_pop", DW'(credit_ok), DW'(1));
         tick();
      end
      check("drain_empty", DW'(valid_out), DW'(0));

      // job accounting
      ready_in = 1'b0;
      send_lines(10, 2000);
      pulse_start(32'd10);
      check("job_done_early", DW'(done), DW'(0));
      ready_in = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (lines_done == 32'd10) seen = 1'b1;
         else tick();
      end
      check("job_lines_done_10", DW'(lines_done), DW'(10));
      tick();
      check("job_done", DW'(done), DW'(1));
      check("job_lines_hold", DW'(lines_done), DW'(10));
      pulse_start(32'd0);
      check("restart_done_clr", DW'(done), DW'(0));
      check("restart_lines_clr", DW'(lines_done), DW'(0));
      tick();
      check("zero_job_done", DW'(done), DW'(1));

      // errors
      ready_in = 1'b0;
      valid_in = 1'b1;
      data_in  = mk(3000);
      sb_q.push_back(mk(3000));
      tick();
      valid_in = 1'b0;
      check("err_unexp_set", DW'(err_unexpected), DW'(1));
      check("err_ovf_clear", DW'(err_overflow), DW'(0));
      for (int i = 0; i < DEPTH; i++) begin
         rd_issue = 1'b1;
         tick();
      end
      rd_issue = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         valid_in = 1'b1;
         data_in  = mk(3000 + i);
         sb_q.push_back(mk(3000 + i));
         tick();
      end
      check("err_ovf_before", DW'(err_overflow), DW'(0));
      valid_in = 1'b1;
      data_in  = mk(9999);
      tick();
      valid_in = 1'b0;
      check("err_ovf_set", DW'(err_overflow), DW'(1));
      ready_in = 1'b1;
      for (int i = 0; i < DEPTH + 4; i++) tick();
      check("ovf_drained", DW'(valid_out), DW'(0));
      check("err_ovf_sticky", DW'(err_overflow), DW'(1));
      check("err_unexp_sticky", DW'(err_unexpected), DW'(1));
      check("sb_empty_mid", DW'(sb_q.size()), DW'(0));

      // asynchronous reset mid-burst
      ready_in = 1'b0;
      send_lines(20, 4000);
      pulse_start(32'd100);
      check("pre_rst_valid", DW'(valid_out), DW'(1));
      check("pre_rst_credit", DW'(credit_ok), DW'(1));
      #2;
      reset = 1'b0;
      sb_q.delete();
      #1;
      check("arst_valid_out", DW'(valid_out), DW'(0));
      check("arst_data_out", data_out, '0);
      check("arst_credit_ok", DW'(credit_ok), DW'(1));
      check("arst_lines_done", DW'(lines_done), DW'(0));
      check("arst_done", DW'(done), DW'(0));
      check("arst_err_ovf", DW'(err_overflow), DW'(0));
      check("arst_err_unexp", DW'(err_unexpected), DW'(0));
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("post_rst_valid", DW'(valid_out), DW'(0));
      check("sb_empty_end", DW'(sb_q.size()), DW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
